// File: rtl/score_bcd_digits_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : score_bcd_digits_if
// Description : Bundle between the instrument controller and the binary-to-BCD
//               converter that feeds the four-digit seven-segment driver.
//               master : the controller side (drives start/value, reads the
//                        status flags and digits)
//               slave  : the converter side
//               Ports carried:
//                 start     request a conversion (master -> slave)
//                 value     unsigned binary value, IN_W bits (master -> slave)
//                 busy      conversion in progress (slave -> master)
//                 done      one-cycle pulse, new digits valid (slave -> master)
//                 overflow  last accepted value was clamped (slave -> master)
//                 dig_*     four BCD digit nibbles, thousands..ones
// Revision    : 1.0 - initial release
// ============================================================================
interface score_bcd_digits_if #(
  parameter int IN_W = 14
);
  logic            start;
  logic [IN_W-1:0] value;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [3:0]      dig_thou;
  logic [3:0]      dig_hund;
  logic [3:0]      dig_tens;
  logic [3:0]      dig_ones;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  overflow,
    input  dig_thou,
    input  dig_hund,
    input  dig_tens,
    input  dig_ones
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output overflow,
    output dig_thou,
    output dig_hund,
    output dig_tens,
    output dig_ones
  );
endinterface
`default_nettype wire

// File: rtl/score_bcd_digits.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : score_bcd_digits
// Description : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//               per clock). A start seen in IDLE clamps the input to MAX_VAL,
//               latches it, and runs IN_W shift cycles. The final digits are
//               written to the output registers in one step, so the display
//               multiplexer never observes a partially converted value.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous, active-high reset
//               bus  - score_bcd_digits_if.slave (start, value, busy, done,
//                      overflow, dig_thou, dig_hund, dig_tens, dig_ones)
// Parameters  : IN_W    - binary input width (= shift cycles per conversion)
//               MAX_VAL - clamp ceiling, <= 9999 and < 2**IN_W
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_digits #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  wire logic          clk,
  input  wire logic          rst,
  score_bcd_digits_if.slave  bus
);

  // Counter wide enough to hold IN_W-1 for any legal IN_W.
  localparam int              CNT_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W-1:0] C_MAX  = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(IN_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          state_q,    state_d;
  logic [IN_W-1:0] bin_q,      bin_d;
  logic [15:0]     scratch_q,  scratch_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     digits_q,   digits_d;

  // --------------------------------------------------------------------------
  // Add-3 correction: every nibble >= 5 is bumped by 3 before the shift so
  // that doubling it carries correctly into the next decimal position.
  // All four nibbles are corrected in parallel from the pre-shift value.
  // --------------------------------------------------------------------------
  logic [15:0] w_adj;

  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    logic [3:0] w_nib;
    assign w_nib = scratch_q[4*gi +: 4];
    assign w_adj[4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
  end

  // One-bit left shift of {scratch, bin}: the binary MSB enters scratch bit 0.
  logic [15:0]     w_scratch_sh;
  logic [IN_W-1:0] w_bin_sh;

  assign w_scratch_sh = {w_adj[14:0], bin_q[IN_W-1]};
  assign w_bin_sh     = bin_q << 1;

  // Input clamp, evaluated only on the accepting edge.
  logic            w_over;
  logic [IN_W-1:0] w_clamped;

  assign w_over    = (bus.value > C_MAX);
  assign w_clamped = w_over ? C_MAX : bus.value;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;            // done is a single-cycle pulse
    overflow_d = overflow_q;
    digits_d   = digits_q;

    unique case (state_q)
      S_IDLE: begin
        // start is only honoured here, which also covers the done cycle and
        // gives back-to-back conversions an IN_W+1 cycle spacing.
        if (bus.start) begin
          bin_d      = w_clamped;
          overflow_d = w_over;
          scratch_d  = '0;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // start and value are deliberately not looked at in this state.
        scratch_d = w_scratch_sh;
        bin_d     = w_bin_sh;
        count_d   = count_q + 1'b1;

        if (count_q == C_LAST) begin
          // Publish the fully shifted result straight from the shifter so
          // the digits flip in a single edge together with done.
          digits_d = w_scratch_sh;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          count_d  = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers (asynchronous reset aborts any conversion in flight)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all driven straight from flops
  // --------------------------------------------------------------------------
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.dig_thou = digits_q[15:12];
  assign bus.dig_hund = digits_q[11:8];
  assign bus.dig_tens = digits_q[7:4];
  assign bus.dig_ones = digits_q[3:0];

endmodule
`default_nettype wire

// File: doc/score_bcd_digits.md
Name: score_bcd_digits

Overview:
Sequential binary-to-BCD converter that feeds the four-digit seven-segment display driver. It takes a binary score or count from the instrument controller and produces four decimal digit nibbles. It uses the shift-and-add-3 (double-dabble) method, one bit per clock. Results are held stable between conversions so the display's multiplexing never sees partial values.

Parameters:
IN_W, 14, width of the binary input; the number of shift cycles per conversion equals IN_W.
MAX_VAL, 9999, clamp ceiling applied to the input; must be <= 9999 and < 2^IN_W.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request a conversion; sampled only in IDLE.
value  input  IN_W  unsigned binary value; sampled on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when new digits are valid.
overflow  output  1  registered; high if the last accepted value exceeded MAX_VAL.
dig_thou  output  4  thousands digit; drives the leftmost display position.
dig_hund  output  4  hundreds digit.
dig_tens  output  4  tens digit.
dig_ones  output  4  ones digit; drives the rightmost display position.

Behaviour:
- Reset (asynchronous, active-high, rst) forces:
  - state IDLE;
  - busy=0, done=0, overflow=0;
  - all four digits = 4'h0;
  - internal shift register and bit counter cleared.
- Reset asserted mid-conversion aborts it. No done pulse is produced and the digits read 0 after reset.
- States: IDLE, SHIFT.
- IDLE: on an edge with start=1:
  - capture v = (value > MAX_VAL) ? MAX_VAL : value into the binary shift register;
  - set overflow = (value > MAX_VAL);
  - clear the 16-bit BCD scratch register and set count=0;
  - set busy=1 and go to SHIFT.
  Digit outputs keep their previous values.
- SHIFT: each edge does the following:
  - every scratch nibble >= 5 gets +3, applied to all four nibbles in parallel on the pre-shift value;
  - then {scratch, bin} shifts left by one; the binary MSB enters scratch bit 0;
  - count increments.
- The edge where count == IN_W-1 performs the final shift and then:
  - writes the final adjusted+shifted scratch nibbles directly to dig_thou..dig_ones;
  - sets done=1 and busy=0, and returns to IDLE.
- Latency: start accepted at edge k. busy is high after edges k..k+13. After edge k+IN_W (k+14 by default), done=1, busy=0 and the new digits are visible.
- done is high for exactly one cycle and is cleared on the next edge.
- start while busy=1 is ignored: it is neither queued nor re-latched, and value changes during SHIFT have no effect.
- start=1 in the cycle where done=1 (state already IDLE) is accepted on that edge. Back-to-back conversions are therefore spaced IN_W+1 cycles apart.
- Digits are always valid BCD (0-9) and change only on the done-producing edge or on reset.
- overflow updates only on an accepting edge and holds until the next accept or reset.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle. Required: all outputs 0 immediately, without waiting for a clk edge.
- value=1234, start for 1 cycle. Required:
  - busy high for 14 cycles;
  - done pulses exactly once, 14 edges after the accept;
  - digits 1,2,3,4; overflow=0.
- value=0, then value=9999 back-to-back, with the second start asserted during the done cycle. Required:
  - first result 0,0,0,0;
  - second result 9,9,9,9;
  - second done exactly 15 cycles after the first.
- value=12345 (exceeds MAX_VAL). Required: digits 9,9,9,9 and overflow=1. A following value=7 gives 0,0,0,7 and overflow=0.
- value=5678 accepted; at cycle 3 of SHIFT drive start=1 and value=1111. Required: the second start is ignored, result is 5,6,7,8, and only one done pulse occurs.
- Convert 4321, then assert rst at SHIFT cycle 7. Required:
  - digits drop to 0 immediately and no done pulse occurs;
  - after reset release, a new start with 80 yields 0,0,8,0.
